// File: rtl/lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_port
// Brief    : RV32I load/store unit driving a req/ack data-memory port.
//            Optional REQ timeout enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;

    logic        w_access;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_ext;

    assign w_access     = mem_read | mem_write;
    assign w_is_word    = funct3[1];
    assign w_is_half    = ~funct3[1] & funct3[0];
    assign w_misaligned = (w_is_word & (|addr[1:0])) | (w_is_half & addr[0]);

    // Held combinationally in IDLE so the issuing instruction never advances.
    assign stall = ((r_state == c_ST_IDLE) & w_access) | (r_state == c_ST_REQ);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = store_data;
        if (w_is_word) begin
            w_be    = 4'b1111;
            w_wdata = store_data;
        end else if (w_is_half) begin
            w_be    = 4'b0011 << {addr[1], 1'b0};
            w_wdata = {2{store_data[15:0]}};
        end else begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{store_data[7:0]}};
        end
    end

    assign w_lane_byte = dmem_rdata[{r_offset, 3'b000} +: 8];
    assign w_lane_half = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_ext = dmem_rdata;
        if (r_funct3[1]) begin
            w_load_ext = dmem_rdata;
        end else if (r_funct3[0]) begin
            w_load_ext = {{16{~r_funct3[2] & w_lane_half[15]}}, w_lane_half};
        end else begin
            w_load_ext = {{24{~r_funct3[2] & w_lane_byte[7]}}, w_lane_byte};
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_bus_error;

    assign bus_error = r_bus_error;
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_funct3    <= 3'b000;
            r_offset    <= 2'b00;
            load_data   <= 32'd0;
            done        <= 1'b0;
            misaligned  <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
            r_bus_error <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_bus_error <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            r_state    <= c_ST_DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                            load_data  <= 32'd0;
                        end else begin
                            r_state    <= c_ST_REQ;
                            r_funct3   <= funct3;
                            r_offset   <= addr[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                            r_tmo_cnt  <= 8'd0;
`endif
                        end
                    end
                end
                c_ST_REQ: begin
                    // An ack on the timeout edge still completes normally.
                    if (dmem_ack) begin
                        r_state  <= c_ST_DONE;
                        dmem_req <= 1'b0;
                        done     <= 1'b1;
                        if (!dmem_we) begin
                            load_data <= w_load_ext;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_state     <= c_ST_DONE;
                        dmem_req    <= 1'b0;
                        done        <= 1'b1;
                        r_bus_error <= 1'b1;
                        if (!dmem_we) begin
                            load_data <= 32'd0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_port
// Brief    : Randomized self-checking bench for lsu_dmem_port with a
//            behavioural memory and load-result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_port;

    localparam int unsigned c_TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load_data;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_load_data = 32'd0;

    lsu_dmem_port #(
        .TIMEOUT_CYCLES(c_TMO)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge, in an IDLE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input int waits);
        int          size;
        int          off;
        bit          mis;
        bit          tmo;
        int          exp_lat;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] mask;
        logic [31:0] val;
        int          req_cycles;
        int          stall_cnt;
        int          cyc;
        bit          done_seen;

        size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        off  = int'(a & 32'd3);
        mis  = (off % size) != 0;
        tmo  = 1'b0;
`ifdef LSU_TIMEOUT_EN
        tmo  = !mis && (waits >= int'(c_TMO));
`endif
        exp_lat = mis ? 1 : (tmo ? int'(c_TMO) + 1 : waits + 2);
        exp_be  = ((32'd1 << size) - 32'd1) << off;
        case (size)
            1:       exp_wd = (sd & 32'hFF) * 32'h0101_0101;
            2:       exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
            default: exp_wd = sd;
        endcase
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (rdat >> (8 * off)) & mask;
        if (size < 4 && !f3[2] && val[8 * size - 1]) val = val | ~mask;

        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        check_val("stall_on_request", stall, 1);

        req_cycles = 0; stall_cnt = 0; cyc = 0; done_seen = 0;
        while (!done_seen && cyc < 300) begin
            if (stall) stall_cnt++;
            if (dmem_req) begin
                check_val("bus_we", dmem_we, wr);
                check_val("bus_addr", dmem_addr, a & 32'hFFFF_FFFC);
                check_val("bus_be", dmem_be, exp_be);
                if (wr) check_val("bus_wdata", dmem_wdata, exp_wd);
                if (req_cycles == waits) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdat;
                end
                req_cycles++;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            // Core-side inputs must be ignored once the request is captured.
            addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
            cyc++;
            if (done) done_seen = 1;
        end

        if (mis) exp_load_data = 32'd0;
        else if (!wr) exp_load_data = tmo ? 32'd0 : val;

        check_val("done_seen", done_seen, 1);
        check_val("latency", cyc, exp_lat);
        check_val("stall_cycles", stall_cnt, exp_lat);
        check_val("stall_in_done", stall, 0);
        check_val("misaligned", misaligned, mis);
        check_val("bus_error", bus_error, tmo);
        check_val("req_in_done", dmem_req, 0);
        check_val("load_data", load_data, exp_load_data);
        if (mis) check_val("mis_no_req", req_cycles, 0);

        mem_read = 1'b0; mem_write = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check_val("done_pulse", done, 0);
        check_val("mis_pulse", misaligned, 0);
        check_val("idle_no_req", dmem_req, 0);
        check_val("idle_stall", stall, 0);
        check_val("load_hold", load_data, exp_load_data);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_load_data", load_data, 0);
        check_val("rst_req", dmem_req, 0);
        check_val("rst_we", dmem_we, 0);
        check_val("rst_addr", dmem_addr, 0);
        check_val("rst_be", dmem_be, 0);
        check_val("rst_wdata", dmem_wdata, 0);
        check_val("rst_done", done, 0);
        check_val("rst_mis", misaligned, 0);
        check_val("rst_berr", bus_error, 0);
        check_val("rst_stall", stall, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_access(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
        check_val("tp_lb", load_data, 32'hFFFF_FF80);
        run_access(1, 0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 3);
        check_val("tp_lhu", load_data, 32'h0000_BEEF);
        run_access(0, 1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'd0, 1);
        check_val("tp_sb_keeps", load_data, 32'h0000_BEEF);
        run_access(1, 0, 3'b010, 32'h0000_0006, 32'd0, 32'h1234_5678, 0);
        check_val("tp_lw_mis", load_data, 32'd0);

        // Reset in the second REQ cycle of a word store.
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040; store_data = $urandom;
        @(posedge clk); #1;
        check_val("sw_req", dmem_req, 1);
        @(posedge clk); #1;
        check_val("sw_req2", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        mem_write = 1'b0;
        #1;
        check_val("arst_req", dmem_req, 0);
        check_val("arst_we", dmem_we, 0);
        check_val("arst_addr", dmem_addr, 0);
        check_val("arst_be", dmem_be, 0);
        check_val("arst_wdata", dmem_wdata, 0);
        check_val("arst_stall", stall, 0);
        exp_load_data = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1, 0, 3'b001, 32'h0000_0082, 32'd0, 32'h7FFF_0000, 2);

`ifdef LSU_TIMEOUT_EN
        run_access(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 100);
        check_val("tmo_load", load_data, 32'd0);
        run_access(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, int'(c_TMO) - 1);
        check_val("tmo_ack_wins", load_data, 32'hCAFE_F00D);
        run_access(0, 1, 3'b010, 32'h0000_0200, 32'h1111_2222, 32'd0, 100);
`endif

        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_access(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
